// File: rtl/logic_analyzer_capture.sv
// rtl/logic_analyzer_capture.sv - circular sample capture buffer with byte-serial UART dump
// Define LA_HEADER_EN to prefix each dump with a 16-bit sample count, MSB first.
module logic_analyzer_capture #(
  parameter int SAMPLE_BYTES = 2,
  parameter int DEPTH        = 512
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      dev_command_started,
  input  logic [4:0]                dev_command,
  output logic                      dev_busy,
  output logic                      uart_tx_send_byte,
  output logic [7:0]                uart_tx_byte,
  input  logic                      uart_tx_active,
  input  logic                      data_strobe,
  input  logic [8*SAMPLE_BYTES-1:0] data,
  output logic                      led_full,
  output logic                      overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 8 * SAMPLE_BYTES;
  localparam int SW = (DW > 16) ? DW : 16;
  localparam int BW = (SAMPLE_BYTES > 2) ? $clog2(SAMPLE_BYTES) : 1;
`ifdef LA_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_CAPTURE, S_HDR, S_RD_REQ, S_RD_WAIT, S_SEND, S_GAP
  } state_t;

  state_t          r_state, w_next;
  logic [AW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_cnt, r_left;
  logic [SW-1:0]   r_sh;
  logic [BW-1:0]   r_bi;
  logic            r_hdr, r_ovf, r_full, r_busy;
  logic [DW-1:0]   r_ram [DEPTH];
  logic [DW-1:0]   r_rd_data;

  logic            w_capture, w_cmd_clear, w_cmd_read, w_full, w_wr, w_drop, w_last;
  logic [15:0]     w_left16;

  assign w_capture   = (r_state == S_CAPTURE);
  assign w_cmd_clear = w_capture && dev_command_started && (dev_command == 5'd0);
  assign w_cmd_read  = w_capture && dev_command_started && (dev_command == 5'd1);
  assign w_full      = (r_cnt == CW'(DEPTH));
  // A strobe coinciding with LA_CLEAR is discarded without flagging overflow.
  assign w_wr        = w_capture && data_strobe && !w_cmd_clear && !w_full;
  assign w_drop      = data_strobe && !w_cmd_clear && (!w_capture || w_full);
  assign w_last      = r_hdr ? (r_bi == BW'(1)) : (r_bi == BW'(SAMPLE_BYTES - 1));
  assign w_left16    = 16'(r_left);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_CAPTURE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CAPTURE: if (w_cmd_read) w_next = HDR_EN ? S_HDR : S_RD_REQ;
      S_HDR:     w_next = S_SEND;
      S_RD_REQ:  w_next = (r_left == '0) ? S_CAPTURE : S_RD_WAIT;
      S_RD_WAIT: w_next = S_SEND;
      S_SEND:    if (!uart_tx_active) w_next = S_GAP;
      S_GAP:     w_next = w_last ? S_RD_REQ : S_SEND;
      default:   w_next = S_CAPTURE;
    endcase
  end

  always_comb begin
    uart_tx_send_byte = (r_state == S_SEND) && !uart_tx_active;
    uart_tx_byte      = (r_state == S_SEND) ? r_sh[7:0] : 8'h00;
    dev_busy          = r_busy;
    led_full          = r_full;
    overflow          = r_ovf;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_left <= '0;
      r_sh   <= '0;
      r_bi   <= '0;
      r_hdr  <= 1'b0;
      r_ovf  <= 1'b0;
      r_full <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_busy <= !w_capture;
      r_full <= w_full;
      if (w_cmd_clear) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_wr) begin
          r_wp  <= r_wp + AW'(1);
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_drop) r_ovf <= 1'b1;
      end
      if (w_cmd_read) r_left <= r_cnt;
      case (r_state)
        S_HDR: begin
          r_sh  <= SW'({w_left16[7:0], w_left16[15:8]});
          r_bi  <= '0;
          r_hdr <= 1'b1;
        end
        S_RD_WAIT: begin
          r_sh  <= SW'(r_rd_data);
          r_bi  <= '0;
          r_hdr <= 1'b0;
        end
        S_SEND: if (!uart_tx_active) r_sh <= r_sh >> 8;
        S_GAP: begin
          if (w_last) begin
            if (!r_hdr) begin
              r_rp   <= r_rp + AW'(1);
              r_cnt  <= r_cnt - CW'(1);
              r_left <= r_left - CW'(1);
            end
            r_hdr <= 1'b0;
          end else begin
            r_bi <= r_bi + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Sample RAM with a registered read port; no writes can occur while a dump reads it.
  always_ff @(posedge clock) begin
    if (w_wr) r_ram[r_wp] <= data;
    r_rd_data <= r_ram[r_rp];
  end
endmodule

// File: tb/tb_logic_analyzer_capture.sv
// tb/tb_logic_analyzer_capture.sv - self-checking bench for logic_analyzer_capture (SAMPLE_BYTES=2, DEPTH=8)
module tb_logic_analyzer_capture;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dev_command_started = 1'b0;
  logic [4:0]  dev_command = 5'd0;
  logic        dev_busy, uart_tx_send_byte, led_full, overflow;
  logic [7:0]  uart_tx_byte;
  logic        uart_tx_active = 1'b0;
  logic        data_strobe = 1'b0;
  logic [15:0] data = 16'h0;

  logic_analyzer_capture #(.SAMPLE_BYTES(2), .DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .dev_command_started(dev_command_started), .dev_command(dev_command),
    .dev_busy(dev_busy), .uart_tx_send_byte(uart_tx_send_byte), .uart_tx_byte(uart_tx_byte),
    .uart_tx_active(uart_tx_active), .data_strobe(data_strobe), .data(data),
    .led_full(led_full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0, n_fail = 0;
  int          stall = 0, cd = 0;
  bit          force_active = 1'b0, u_sent;
  logic [7:0]  rx_q[$];
  logic [15:0] mq[$];
  bit          m_ovf = 1'b0;

  typedef struct { int n; int stall; bit inj; bit full; bit ovf; } vec_t;
  vec_t vecs[6];

  // UART model: records pulses, then stays busy for `stall` cycles after each byte.
  always begin
    @(negedge clock);
    u_sent = uart_tx_send_byte;
    if (u_sent) rx_q.push_back(uart_tx_byte);
    @(posedge clock); #1;
    if (u_sent) cd = stall;
    else if (cd > 0) cd--;
    uart_tx_active = force_active || (cd > 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [15:0] v);
    data = v; data_strobe = 1'b1;
    @(posedge clock); #1;
    data_strobe = 1'b0;
    if (mq.size() < 8) mq.push_back(v);
    else m_ovf = 1'b1;
  endtask

  task automatic cmd(input logic [4:0] c);
    dev_command = c; dev_command_started = 1'b1;
    @(posedge clock); #1;
    dev_command_started = 1'b0;
    if (c == 5'd0) begin mq.delete(); m_ovf = 1'b0; end
  endtask

  task automatic check_flags(input string name);
    idle(2);
    check({name, " led_full"}, led_full, (mq.size() == 8));
    check({name, " overflow"}, overflow, m_ovf);
  endtask

  task automatic do_dump(input string name, input bit inject, input int hold_at,
                         input int reset_at, input bit chk_lat);
    logic [7:0] exp[$];
    int idx = 0, hold_cnt = 0, first = -1, rel_idx = -1, exp_lat;
    bit seen = 1'b0, done = 1'b0, held = 1'b0;
`ifdef LA_HEADER_EN
    exp.push_back(8'h00);
    exp.push_back(8'(mq.size()));
    exp_lat = 2;
`else
    exp_lat = 3;
`endif
    foreach (mq[i]) begin
      exp.push_back(mq[i][7:0]);
      exp.push_back(mq[i][15:8]);
    end
    rx_q.delete();
    cmd(5'd1);
    mq.delete();
    while (!done && idx < 2000) begin
      @(negedge clock); #2;
      idx++;
      data_strobe = 1'b0;
      dev_command_started = 1'b0;
      if (dev_busy) seen = 1'b1;
      if (first < 0 && rx_q.size() > 0) first = idx;
      if (rel_idx >= 0 && idx == rel_idx + 1) check({name, " release"}, rx_q.size(), hold_at + 1);
      if (hold_at > 0 && !held && rx_q.size() == hold_at) begin
        force_active = 1'b1; held = 1'b1; hold_cnt = 20;
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) begin
          check({name, " hold"}, rx_q.size(), hold_at);
          force_active = 1'b0;
          rel_idx = idx;
        end
      end
      if (reset_at > 0 && rx_q.size() == reset_at) begin
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock); #2;
        check({name, " busy"}, dev_busy, 1'b0);
        check({name, " send"}, uart_tx_send_byte, 1'b0);
        check({name, " byte"}, uart_tx_byte, 8'h00);
        check({name, " full"}, led_full, 1'b0);
        check({name, " ovf"}, overflow, 1'b0);
        m_ovf = 1'b0;
        done = 1'b1;
      end else if (seen && !dev_busy) begin
        done = 1'b1;
      end else if (inject && rx_q.size() < exp.size() && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       begin data = 16'($urandom); data_strobe = 1'b1; m_ovf = 1'b1; end
          1:       begin dev_command = 5'd0; dev_command_started = 1'b1; end
          default: begin dev_command = 5'd1; dev_command_started = 1'b1; end
        endcase
      end
    end
    data_strobe = 1'b0;
    dev_command_started = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL %s timeout: dev_busy still %0b after %0d cycles", name, dev_busy, idx);
    end else if (reset_at == 0) begin
      check({name, " busy_seen"}, seen, 1'b1);
      check({name, " nbytes"}, rx_q.size(), exp.size());
      foreach (exp[i]) check($sformatf("%s byte%0d", name, i),
                             (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp[i]);
      if (chk_lat) check({name, " latency"}, first, exp_lat);
      idle(2);
      check({name, " full_after"}, led_full, 1'b0);
      check({name, " ovf_after"}, overflow, m_ovf);
    end
  endtask

  initial begin
    vecs[0] = '{0, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1, 2, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{7, 0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8, 1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{10, 3, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{3, 5, 1'b0, 1'b0, 1'b0};

    idle(3);
    check("rst busy", dev_busy, 1'b0);
    check("rst send", uart_tx_send_byte, 1'b0);
    check("rst byte", uart_tx_byte, 8'h00);
    check("rst full", led_full, 1'b0);
    check("rst ovf", overflow, 1'b0);
    reset = 1'b0;
    idle(1);

    strobe(16'h1234);
    strobe(16'hABCD);
    check_flags("basic");
    do_dump("basic", 1'b0, 0, 0, 1'b1);

    cmd(5'd0);
    for (int i = 0; i < 10; i++) begin
      strobe(16'(i));
      idle(1);
      check($sformatf("fill%0d full", i), led_full, (i >= 7));
      check($sformatf("fill%0d ovf", i), overflow, (i >= 8));
    end
    do_dump("fill", 1'b0, 0, 0, 1'b0);

    data = 16'h7777; data_strobe = 1'b1;
    cmd(5'd0);
    data_strobe = 1'b0;
    check_flags("clr_strobe");
    do_dump("clr_strobe", 1'b0, 0, 0, 1'b0);

    for (int v = 0; v < 6; v++) begin
      cmd(5'd0);
      for (int k = 0; k < vecs[v].n; k++) strobe(16'($urandom));
      idle(2);
      check($sformatf("vec%0d full", v), led_full, vecs[v].full);
      check($sformatf("vec%0d ovf", v), overflow, vecs[v].ovf);
      stall = vecs[v].stall;
      do_dump($sformatf("vec%0d", v), vecs[v].inj, 0, 0, 1'b0);
    end

    stall = 0;
    cmd(5'd0);
    for (int k = 0; k < 3; k++) strobe(16'($urandom));
    do_dump("hold", 1'b0, 2, 0, 1'b0);

    cmd(5'd0);
    for (int k = 0; k < 4; k++) strobe(16'($urandom));
    do_dump("rst_mid", 1'b0, 0, 3, 1'b0);
    idle(2);
    strobe(16'h5555);
    check_flags("post_rst");
    do_dump("post_rst", 1'b0, 0, 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      cmd(5'd0);
      cmd(5'($urandom_range(2, 31)));
      for (int k = $urandom_range(0, 11); k > 0; k--) begin
        strobe(16'($urandom));
        idle($urandom_range(0, 2));
      end
      check_flags($sformatf("rnd%0d", r));
      stall = $urandom_range(0, 3);
      do_dump($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 0, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
